int_to_hex_stream: RTL and testbench

- Registered binary-to-ASCII hex encoder for on-screen debug and register displays.
- Takes an N-nibble value and produces two outputs:
  - all hex characters in parallel, for direct character-buffer writes;
  - a serial MSB-first character stream with valid/ready handshake, for text sinks.
- Sits between CPU/peripheral register taps and the debugger character generator.

---
 rtl/int_to_hex_stream.sv | 126 ++++++++++++
 tb/tb_int_to_hex_stream.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/int_to_hex_stream.sv
// Registered binary-to-ASCII hex encoder: parallel character word plus MSB-first serial stream.
// Optional leading-zero blanking when INT_TO_HEX_STREAM_ZBLANK_EN is defined.
module int_to_hex_stream #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_value,
  output logic [8*NIBBLES-1:0]   par_chr,
  output logic                   par_valid,
  output logic [7:0]             ser_chr,
  output logic                   ser_valid,
  input  logic                   ser_ready,
  output logic                   ser_last
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  function automatic logic [7:0] hex_digit(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  function automatic logic [8*NIBBLES-1:0] encode_all(input logic [4*NIBBLES-1:0] v);
    logic [8*NIBBLES-1:0] r;
    logic [3:0]           nib;
`ifdef INT_TO_HEX_STREAM_ZBLANK_EN
    logic                 leading;
    leading = 1'b1;
`endif
    r = '0;
    for (int k = NIBBLES-1; k >= 0; k--) begin
      nib = v[4*k +: 4];
`ifdef INT_TO_HEX_STREAM_ZBLANK_EN
      if (leading && (nib == 4'h0) && (k != 0)) begin
        r[8*k +: 8] = 8'h20;
      end else begin
        r[8*k +: 8] = hex_digit(nib);
        leading     = 1'b0;
      end
`else
      r[8*k +: 8] = hex_digit(nib);
`endif
    end
    return r;
  endfunction

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [8*NIBBLES-1:0]   par_chr_q, par_chr_d;
  logic                   par_valid_q, par_valid_d;
  logic [7:0]             ser_chr_q, ser_chr_d;
  logic                   ser_last_q, ser_last_d;

  logic [8*NIBBLES-1:0]   enc_in;
  logic [IDX_W-1:0]       idx_nxt;

  assign enc_in  = encode_all(in_value);
  assign idx_nxt = idx_q - IDX_W'(1);

  // par_chr_q only changes on accept, so it doubles as the captured value
  // from which the serial characters are selected.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    par_chr_d   = par_chr_q;
    par_valid_d = 1'b0;
    ser_chr_d   = ser_chr_q;
    ser_last_d  = ser_last_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d     = SEND;
          idx_d       = IDX_W'(NIBBLES-1);
          par_chr_d   = enc_in;
          par_valid_d = 1'b1;
          ser_chr_d   = enc_in[8*(NIBBLES-1) +: 8];
          ser_last_d  = (NIBBLES == 1);
        end
      end
      SEND: begin
        if (ser_ready) begin
          if (idx_q == '0) begin
            state_d    = IDLE;
            ser_chr_d  = 8'h00;
            ser_last_d = 1'b0;
          end else begin
            idx_d      = idx_nxt;
            ser_chr_d  = par_chr_q[{idx_nxt, 3'b000} +: 8];
            ser_last_d = (idx_nxt == '0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= IDX_W'(NIBBLES-1);
      par_chr_q   <= {NIBBLES{8'h30}};
      par_valid_q <= 1'b0;
      ser_chr_q   <= 8'h00;
      ser_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      par_chr_q   <= par_chr_d;
      par_valid_q <= par_valid_d;
      ser_chr_q   <= ser_chr_d;
      ser_last_q  <= ser_last_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign ser_valid = (state_q == SEND);
  assign par_chr   = par_chr_q;
  assign par_valid = par_valid_q;
  assign ser_chr   = ser_chr_q;
  assign ser_last  = ser_last_q;

endmodule

// File: tb/tb_int_to_hex_stream.sv
// Directed self-checking bench for int_to_hex_stream: a 4-digit and a 1-digit instance.
// Blanking vectors run when INT_TO_HEX_STREAM_ZBLANK_EN is defined.
module tb_int_to_hex_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid, in_ready, par_valid, ser_valid, ser_ready, ser_last;
  logic [15:0] in_value;
  logic [31:0] par_chr;
  logic [7:0]  ser_chr;

  logic        in_valid1, in_ready1, par_valid1, ser_valid1, ser_ready1, ser_last1;
  logic [3:0]  in_value1;
  logic [7:0]  par_chr1, ser_chr1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  int_to_hex_stream #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
    .par_chr(par_chr), .par_valid(par_valid), .ser_chr(ser_chr), .ser_valid(ser_valid),
    .ser_ready(ser_ready), .ser_last(ser_last)
  );

  int_to_hex_stream #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_value(in_value1),
    .par_chr(par_chr1), .par_valid(par_valid1), .ser_chr(ser_chr1), .ser_valid(ser_valid1),
    .ser_ready(ser_ready1), .ser_last(ser_last1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one value for a single cycle; returns at the negedge after the accept edge.
  task automatic offer4(input logic [15:0] v);
    in_value = v;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic expect_ser(input string tag, input logic [7:0] c, input logic last);
    check({tag, "_valid"}, ser_valid, 1'b1);
    check({tag, "_chr"},   ser_chr,   c);
    check({tag, "_last"},  ser_last,  last);
    check({tag, "_inrdy"}, in_ready,  1'b0);
  endtask

  task automatic expect_stream(input string tag, input logic [31:0] chars);
    for (int i = 3; i >= 0; i--) begin
      expect_ser($sformatf("%s_c%0d", tag, 3-i), chars[8*i +: 8], i == 0);
      @(negedge clk);
    end
    check({tag, "_end_valid"}, ser_valid, 1'b0);
    check({tag, "_end_inrdy"}, in_ready,  1'b1);
    check({tag, "_end_last"},  ser_last,  1'b0);
  endtask

  initial begin
    logic [7:0] exp1;
    in_valid   = 1'b0; in_value  = '0; ser_ready  = 1'b1;
    in_valid1  = 1'b0; in_value1 = '0; ser_ready1 = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_par",      par_chr,   32'h30303030);
    check("rst_inrdy",    in_ready,  1'b1);
    check("rst_parvalid", par_valid, 1'b0);
    check("rst_servalid", ser_valid, 1'b0);
    check("rst_serlast",  ser_last,  1'b0);
    check("rst_serchr",   ser_chr,   8'h00);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_par",      par_chr,   32'h30303030);
    check("idle_inrdy",    in_ready,  1'b1);
    check("idle_parvalid", par_valid, 1'b0);
    check("idle_servalid", ser_valid, 1'b0);

    // 0x1A9F, sink always ready
    offer4(16'h1A9F);
    check("1a9f_par",      par_chr,   32'h31413946);
    check("1a9f_parvalid", par_valid, 1'b1);
    expect_ser("1a9f_c0", 8'h31, 1'b0);
    @(negedge clk);
    check("1a9f_parpulse", par_valid, 1'b0);
    expect_ser("1a9f_c1", 8'h41, 1'b0);
    @(negedge clk);
    expect_ser("1a9f_c2", 8'h39, 1'b0);
    @(negedge clk);
    expect_ser("1a9f_c3", 8'h46, 1'b1);
    @(negedge clk);
    check("1a9f_end_valid", ser_valid, 1'b0);
    check("1a9f_end_inrdy", in_ready,  1'b1);
    check("1a9f_par_hold",  par_chr,   32'h31413946);

    // 0xBEEF with a 5-cycle stall and an ignored in_valid during SEND
    ser_ready = 1'b0;
    offer4(16'hBEEF);
    check("beef_par", par_chr, 32'h42454546);
    for (int i = 0; i < 5; i++) begin
      expect_ser($sformatf("beef_stall%0d", i), 8'h42, 1'b0);
      if (i == 2) begin
        in_value = 16'h1234;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    check("beef_par_ignored", par_chr,   32'h42454546);
    check("beef_parvalid0",   par_valid, 1'b0);
    ser_ready = 1'b1;
    expect_stream("beef", 32'h42454546);
    check("beef_par_final", par_chr, 32'h42454546);

    // Reset in the middle of a stream
    offer4(16'h1234);
    expect_ser("abort_c0", 8'h31, 1'b0);
    @(negedge clk);
    expect_ser("abort_c1", 8'h32, 1'b0);
    @(negedge clk);
    expect_ser("abort_c2", 8'h33, 1'b0);
    rst = 1'b1;
    #1;
    check("abort_servalid", ser_valid, 1'b0);
    check("abort_par",      par_chr,   32'h30303030);
    check("abort_inrdy",    in_ready,  1'b1);
    check("abort_serlast",  ser_last,  1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("abort_quiet%0d", i), ser_valid, 1'b0);
    end

`ifdef INT_TO_HEX_STREAM_ZBLANK_EN
    offer4(16'h00A0);
    check("zb_00a0_par", par_chr, 32'h20204130);
    expect_stream("zb_00a0", 32'h20204130);
    offer4(16'h0000);
    check("zb_0000_par", par_chr, 32'h20202030);
    expect_stream("zb_0000", 32'h20202030);
    offer4(16'h0F00);
    check("zb_0f00_par", par_chr, 32'h20463030);
    expect_stream("zb_0f00", 32'h20463030);
`else
    offer4(16'h00A0);
    check("nz_00a0_par", par_chr, 32'h30304130);
    expect_stream("nz_00a0", 32'h30304130);
    offer4(16'h0000);
    check("nz_0000_par", par_chr, 32'h30303030);
    expect_stream("nz_0000", 32'h30303030);
`endif

    // Single-digit instance: all 16 nibble values, back to back at full rate
    for (int v = 0; v < 16; v++) begin
      exp1 = (v < 10) ? 8'(8'h30 + v) : 8'(8'h37 + v);
      in_value1 = 4'(v);
      in_valid1 = 1'b1;
      @(negedge clk);
      in_valid1 = 1'b0;
      check($sformatf("n1_%0d_par", v),      par_chr1,   exp1);
      check($sformatf("n1_%0d_parvld", v),   par_valid1, 1'b1);
      check($sformatf("n1_%0d_ser", v),      ser_chr1,   exp1);
      check($sformatf("n1_%0d_servld", v),   ser_valid1, 1'b1);
      check($sformatf("n1_%0d_last", v),     ser_last1,  1'b1);
      check($sformatf("n1_%0d_inrdy0", v),   in_ready1,  1'b0);
      @(negedge clk);
      check($sformatf("n1_%0d_done", v),     ser_valid1, 1'b0);
      check($sformatf("n1_%0d_inrdy1", v),   in_ready1,  1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
